// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: per-frame sweep of enabled mux channels, each settled, converted and
// emitted as one DONE word so the downstream FIFO can pack one frame per sweep.
module adc_channel_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter logic [15:0] TIMEOUT_CODE = 16'h8000
) (
  input  logic        SAMPLE_CLK,
  input  logic        NRST_sync,
  input  logic        ENSAMP_sync,
  input  logic [7:0]  CHEN,
  input  logic [3:0]  SETTLE_CYC,
  input  logic [15:0] FRAME_PERIOD,
  input  logic [15:0] ADC_DOUT,
  input  logic        ADC_EOC,
  output logic        ADC_START,
  output logic [7:0]  ATMCHSEL,
  output logic [15:0] RESULT,
  output logic        DONE,
  output logic        LASTWORD,
  output logic        FRAME_MISS,
  output logic        SEQ_TIMEOUT
);
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT_EOC, EMIT} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  state_t      state;
  logic [15:0] frame_cnt, to_cnt;
  logic [7:0]  mask_q, above, next_ch, first_ch;
  logic [3:0]  settle_cnt;
  logic        frame_tick;
  always_comb begin
    frame_tick = ENSAMP_sync && frame_cnt == '0;
    above      = mask_q & ~(ATMCHSEL | (ATMCHSEL - 8'd1));
    next_ch    = above & (~above + 8'd1);
    first_ch   = CHEN & (~CHEN + 8'd1);
  end
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync)
    if (!NRST_sync) frame_cnt <= '0;
    else if (!ENSAMP_sync || {1'b0, frame_cnt} + 17'd1 >= {1'b0, FRAME_PERIOD}) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + 16'd1;
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync)
    if (!NRST_sync) begin
      state       <= IDLE;
      mask_q      <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      ATMCHSEL    <= '0;
      RESULT      <= '0;
      ADC_START   <= 1'b0;
      DONE        <= 1'b0;
      LASTWORD    <= 1'b0;
      FRAME_MISS  <= 1'b0;
      SEQ_TIMEOUT <= 1'b0;
    end else if (!ENSAMP_sync) begin
      state       <= IDLE;
      mask_q      <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      ATMCHSEL    <= '0;
      ADC_START   <= 1'b0;
      DONE        <= 1'b0;
      LASTWORD    <= 1'b0;
      FRAME_MISS  <= 1'b0;
      SEQ_TIMEOUT <= 1'b0;
    end else begin
      ADC_START  <= 1'b0;
      DONE       <= 1'b0;
      LASTWORD   <= 1'b0;
      FRAME_MISS <= frame_tick && state != IDLE;
      case (state)
        IDLE:
          if (frame_tick && CHEN != '0) begin
            mask_q     <= CHEN;
            ATMCHSEL   <= first_ch;
            settle_cnt <= SETTLE_CYC;
            state      <= SETTLE_CYC == '0 ? START : SETTLE;
            ADC_START  <= SETTLE_CYC == '0;
          end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) begin
            state     <= START;
            ADC_START <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT_EOC;
        end
        WAIT_EOC:
          if (ADC_EOC || to_cnt == TO_LAST) begin
            RESULT      <= ADC_EOC ? ADC_DOUT : TIMEOUT_CODE;
            SEQ_TIMEOUT <= SEQ_TIMEOUT | ~ADC_EOC;
            DONE        <= 1'b1;
            LASTWORD    <= above == '0;
            state       <= EMIT;
          end else to_cnt <= to_cnt + 16'd1;
        EMIT:
          if (above == '0) begin
            ATMCHSEL <= '0;
            state    <= IDLE;
          end else begin
            ATMCHSEL   <= next_ch;
            settle_cnt <= SETTLE_CYC;
            state      <= SETTLE_CYC == '0 ? START : SETTLE;
            ADC_START  <= SETTLE_CYC == '0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
